// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with a single outstanding imem request and deferred redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'hFC000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        BranchD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] RD,
  output logic [31:0] PCPlus4F,
  output logic [31:0] PCF,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_buf;
  logic [31:0] redirect_target;
  logic        redirect_pending;

  // A branch arriving in the same cycle as the response must win over the stale data.
  logic        branch_take;
  logic        redirect_now;
  logic [31:0] redirect_pc;

  assign branch_take  = BranchD && !StallF;
  assign redirect_now = redirect_pending || branch_take;
  assign redirect_pc  = branch_take ? PCBranchD : redirect_target;

  assign PCF       = pc;
  assign imem_addr = pc;
  assign PCPlus4F  = pc + 32'd4;
  assign imem_req  = (state == REQ);
  assign FetchBusy = (state != VALID);
  assign RD        = (state == VALID) ? instr_buf : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      instr_buf        <= NOP_INSTR;
      redirect_target  <= 32'd0;
      redirect_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (BranchD) pc <= PCBranchD;
          state <= REQ;
        end
        REQ: begin
          // PC is frozen while the request is in flight; redirects are parked.
          if (branch_take) begin
            redirect_target  <= PCBranchD;
            redirect_pending <= 1'b1;
          end
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (redirect_now) begin
              pc               <= redirect_pc;
              redirect_pending <= 1'b0;
              state            <= REQ;
            end else begin
              instr_buf <= imem_rdata;
              state     <= VALID;
            end
          end else if (branch_take) begin
            redirect_target  <= PCBranchD;
            redirect_pending <= 1'b1;
          end
        end
        VALID: begin
          if (!StallF) begin
            pc    <= BranchD ? PCBranchD : pc + 32'd4;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF;
  logic        BranchD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] RD;
  logic [31:0] PCPlus4F;
  logic [31:0] PCF;
  logic        FetchBusy;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .BranchD(BranchD), .PCBranchD(PCBranchD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .RD(RD), .PCPlus4F(PCPlus4F),
    .PCF(PCF), .FetchBusy(FetchBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_busy(input string tag, input logic [31:0] addr);
    check({tag, ".req"},  {31'd0, imem_req}, 32'd1);
    check({tag, ".addr"}, imem_addr, addr);
    check({tag, ".busy"}, {31'd0, FetchBusy}, 32'd1);
    check({tag, ".rd"},   RD, NOP);
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b0; BranchD = 1'b0; PCBranchD = 32'd0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    tick(); tick();
    check("rst.req",  {31'd0, imem_req}, 32'd0);
    check("rst.busy", {31'd0, FetchBusy}, 32'd1);
    check("rst.rd",   RD, NOP);
    check("rst.pcf",  PCF, 32'd0);
    check("rst.pc4",  PCPlus4F, 32'd4);

    // basic fetch
    rst_n = 1'b1;
    check("idle.req", {31'd0, imem_req}, 32'd0);
    tick();
    check_busy("req0", 32'd0);
    imem_ready = 1'b1;
    tick();
    check("wait0.req", {31'd0, imem_req}, 32'd0);
    check("wait0.busy", {31'd0, FetchBusy}, 32'd1);
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h20080005;
    tick();
    imem_rvalid = 1'b0;
    check("valid0.rd",   RD, 32'h20080005);
    check("valid0.busy", {31'd0, FetchBusy}, 32'd0);
    check("valid0.pc4",  PCPlus4F, 32'd4);
    tick();
    check("req1.addr", imem_addr, 32'd4);

    // imem_ready held low
    for (int i = 0; i < 3; i++) begin
      tick();
      check_busy("hold", 32'd4);
    end

    // stall in VALID
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
    tick();
    imem_rvalid = 1'b0; StallF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall.rd",   RD, 32'h11111111);
      check("stall.pcf",  PCF, 32'd4);
      check("stall.busy", {31'd0, FetchBusy}, 32'd0);
    end
    StallF = 1'b0;
    tick();
    check("unstall.pcf", PCF, 32'd8);

    // redirect during WAIT discards the returned word
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; BranchD = 1'b1; PCBranchD = 32'h40;
    tick();
    check("redir.pcf_frozen", PCF, 32'd8);
    BranchD = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_rvalid = 1'b0;
    check_busy("redir", 32'h40);

    // reset mid-WAIT, then late response
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; rst_n = 1'b0;
    tick();
    check("rstw.req", {31'd0, imem_req}, 32'd0);
    check("rstw.pcf", PCF, 32'd0);
    check("rstw.rd",  RD, NOP);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h22222222;
    tick();
    imem_rvalid = 1'b0;
    check_busy("late", 32'd0);

    // wraparound, using an IDLE branch to reach the top of memory
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; BranchD = 1'b1; PCBranchD = 32'hFFFFFFFC;
    tick();
    BranchD = 1'b0;
    check("wrap.pcf", PCF, 32'hFFFFFFFC);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h33333333;
    tick();
    imem_rvalid = 1'b0;
    check("wrap.rd",  RD, 32'h33333333);
    check("wrap.pc4", PCPlus4F, 32'd0);
    tick();
    check("wrap.addr", imem_addr, 32'd0);

    // a later branch overwrites the pending target
    BranchD = 1'b1; PCBranchD = 32'h80; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; PCBranchD = 32'h100;
    tick();
    BranchD = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h44444444;
    tick();
    imem_rvalid = 1'b0;
    check_busy("overwrite", 32'h100);

    // branch taken from VALID
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h55555555;
    tick();
    imem_rvalid = 1'b0;
    check("vbr.rd", RD, 32'h55555555);
    BranchD = 1'b1; PCBranchD = 32'h200;
    tick();
    BranchD = 1'b0;
    check_busy("vbr", 32'h200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
